// File: rtl/switch_debounce.sv
// Switch debouncer: synchronizes a vector of raw board switch levels, then
// commits a new debounced value only after the synchronized input has held
// the same non-committed value for CNT_MAX+1 consecutive samples.
module switch_debounce #(
   parameter int WIDTH   = 19,
   parameter int CNT_MAX = 1000000
) (
   input  logic             switclk,
   input  logic             switrst_n,
   input  logic [WIDTH-1:0] sw_raw,
   output logic [WIDTH-1:0] switch_o,
   output logic             sw_chg,
   output logic [WIDTH-1:0] sw_chg_mask,
   output logic             sw_busy
);

   // Counter only ever needs to reach CNT_MAX-1.
   localparam int CW = $clog2(CNT_MAX);
   localparam logic [CW-1:0] CNT_LAST = CW'(CNT_MAX - 1);

   typedef enum logic [1:0] {
      IDLE,
      COUNT,
      COMMIT
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] sync1_q, sync2_q;
   logic [WIDTH-1:0] cand_q, cand_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] switch_q, switch_d;
   logic [WIDTH-1:0] mask_q, mask_d;
   logic             chg_q, chg_d;

   // Two-flop synchronizer for the asynchronous switch levels.
   always_ff @(posedge switclk or negedge switrst_n) begin
      if (!switrst_n) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= sw_raw;
         sync2_q <= sync1_q;
      end
   end

   // FSM state, candidate, counter and registered outputs.
   always_ff @(posedge switclk or negedge switrst_n) begin
      if (!switrst_n) begin
         state_q  <= IDLE;
         cand_q   <= '0;
         cnt_q    <= '0;
         switch_q <= '0;
         mask_q   <= '0;
         chg_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cand_q   <= cand_d;
         cnt_q    <= cnt_d;
         switch_q <= switch_d;
         mask_q   <= mask_d;
         chg_q    <= chg_d;
      end
   end

   // Next-state logic: a bounce back to the committed value abandons the
   // window, a new candidate restarts it, and a full window leads to COMMIT.
   always_comb begin
      state_d  = state_q;
      cand_d   = cand_q;
      cnt_d    = cnt_q;
      switch_d = switch_q;
      mask_d   = mask_q;
      chg_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (sync2_q != switch_q) begin
               cand_d  = sync2_q;
               cnt_d   = '0;
               state_d = COUNT;
            end
         end
         COUNT: begin
            if (sync2_q == switch_q) begin
               cnt_d   = '0;
               state_d = IDLE;
            end else if (sync2_q != cand_q) begin
               cand_d = sync2_q;
               cnt_d  = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = COMMIT;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         COMMIT: begin
            switch_d = cand_q;
            mask_d   = cand_q ^ switch_q;
            chg_d    = 1'b1;
            state_d  = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign switch_o    = switch_q;
   assign sw_chg      = chg_q;
   assign sw_chg_mask = mask_q;
   assign sw_busy     = (state_q != IDLE);

endmodule

// File: tb/tb_switch_debounce.sv
// Testbench for switch_debounce: directed scenarios with literal expectations
// plus randomized switch activity checked every cycle against a run-length
// model of the debouncing rules.
module tb_switch_debounce;

   localparam int WIDTH   = 19;
   localparam int CNT_MAX = 4;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [WIDTH-1:0] sw_raw;
   logic [WIDTH-1:0] switch_o;
   logic             sw_chg;
   logic [WIDTH-1:0] sw_chg_mask;
   logic             sw_busy;

   int checks    = 0;
   int errors    = 0;
   int chgCount  = 0;
   bit checkEn   = 1'b0;

   // Model state: synchronizer stages, committed value, current run of
   // identical samples differing from the committed value.
   logic [WIDTH-1:0] ms1 = '0, ms2 = '0, mSample = '0;
   logic [WIDTH-1:0] mOut = '0, mMask = '0, runVal = '0;
   int               runLen = 0;
   bit               mPend = 1'b0;
   bit               mChg = 1'b0;

   always #5 clk = ~clk;

   switch_debounce #(
      .WIDTH  (WIDTH),
      .CNT_MAX(CNT_MAX)
   ) dut (
      .switclk    (clk),
      .switrst_n  (rst_n),
      .sw_raw     (sw_raw),
      .switch_o   (switch_o),
      .sw_chg     (sw_chg),
      .sw_chg_mask(sw_chg_mask),
      .sw_busy    (sw_busy)
   );

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: a value commits once CNT_MAX+1 consecutive
   // synchronized samples equal it and differ from the committed value;
   // the sample taken on the commit edge itself is ignored.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ms1 = '0; ms2 = '0; mOut = '0; mMask = '0; runVal = '0;
         runLen = 0; mPend = 1'b0; mChg = 1'b0;
      end else begin
         mSample = ms2;
         ms2 = ms1;
         ms1 = sw_raw;
         mChg = 1'b0;
         if (mPend) begin
            mMask  = runVal ^ mOut;
            mOut   = runVal;
            mChg   = 1'b1;
            mPend  = 1'b0;
            runLen = 0;
         end else begin
            if (mSample == mOut) runLen = 0;
            else if (runLen > 0 && mSample == runVal) runLen++;
            else begin
               runVal = mSample;
               runLen = 1;
            end
            if (runLen == CNT_MAX + 1) mPend = 1'b1;
         end
      end
   end

   // Per-cycle comparison of the DUT against the model.
   always @(negedge clk) begin
      if (checkEn) begin
         checkOutput("switch_o", 32'(switch_o), 32'(mOut));
         checkOutput("sw_chg", 32'(sw_chg), 32'(mChg));
         checkOutput("sw_chg_mask", 32'(sw_chg_mask), 32'(mMask));
         checkOutput("sw_busy", 32'(sw_busy), 32'(runLen > 0 || mPend));
         if (sw_chg === 1'b1) chgCount++;
      end
   end

   task automatic applyStimulus(input logic [WIDTH-1:0] value, input int cycles);
      sw_raw = value;
      repeat (cycles) @(negedge clk);
   endtask

   // Pulse reset mid-cycle and release it on a falling edge.
   task automatic doReset();
      @(negedge clk);
      #2 rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Called right after reset release with sw_raw already at value:
   // the commit must land on edge CNT_MAX+4 with busy high on edges 3..CNT_MAX+3.
   task automatic latencyCheck(input string tag, input logic [WIDTH-1:0] value);
      for (int k = 1; k <= CNT_MAX + 6; k++) begin
         @(negedge clk);
         checkOutput({tag, " switch_o"}, 32'(switch_o), (k >= CNT_MAX + 4) ? 32'(value) : 32'd0);
         checkOutput({tag, " sw_chg"}, 32'(sw_chg), (k == CNT_MAX + 4) ? 32'd1 : 32'd0);
         checkOutput({tag, " mask"}, 32'(sw_chg_mask), (k >= CNT_MAX + 4) ? 32'(value) : 32'd0);
         checkOutput({tag, " sw_busy"}, 32'(sw_busy), (k >= 3 && k <= CNT_MAX + 3) ? 32'd1 : 32'd0);
      end
   endtask

   initial begin
      int c0;
      int r;
      rst_n  = 1'b1;
      sw_raw = '0;
      #1 rst_n = 1'b0;
      #2;
      checkOutput("reset switch_o", 32'(switch_o), 32'd0);
      checkOutput("reset sw_chg", 32'(sw_chg), 32'd0);
      checkOutput("reset mask", 32'(sw_chg_mask), 32'd0);
      checkOutput("reset sw_busy", 32'(sw_busy), 32'd0);
      repeat (3) @(negedge clk);
      rst_n   = 1'b1;
      checkEn = 1'b1;

      // Single bit rising after reset: latency and busy window.
      doReset();
      sw_raw = 19'h00001;
      latencyCheck("lat1", 19'h00001);

      // Short glitch never commits.
      doReset();
      c0 = chgCount;
      applyStimulus(19'h00010, 2);
      applyStimulus(19'h00000, 15);
      checkOutput("glitch pulses", 32'(chgCount - c0), 32'd0);
      checkOutput("glitch switch_o", 32'(switch_o), 32'd0);
      checkOutput("glitch sw_busy", 32'(sw_busy), 32'd0);

      // Bit 15 toggling every 3 cycles, then held.
      doReset();
      c0 = chgCount;
      for (int i = 0; i < 20; i++) begin
         if (i % 3 == 0) sw_raw = sw_raw ^ 19'h08000;
         @(negedge clk);
      end
      applyStimulus(19'h08000, 15);
      checkOutput("toggle pulses", 32'(chgCount - c0), 32'd1);
      checkOutput("toggle switch_o", 32'(switch_o), 32'h08000);

      // All ones to all zeros.
      doReset();
      applyStimulus(19'h7FFFF, 15);
      c0 = chgCount;
      applyStimulus(19'h00000, 15);
      checkOutput("allclr pulses", 32'(chgCount - c0), 32'd1);
      checkOutput("allclr mask", 32'(sw_chg_mask), 32'h7FFFF);
      checkOutput("allclr switch_o", 32'(switch_o), 32'd0);

      // Reset in the middle of a counting window.
      doReset();
      applyStimulus(19'h00005, 12);
      applyStimulus(19'h00009, 5);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("midrst switch_o", 32'(switch_o), 32'd0);
      checkOutput("midrst mask", 32'(sw_chg_mask), 32'd0);
      checkOutput("midrst sw_busy", 32'(sw_busy), 32'd0);
      checkOutput("midrst sw_chg", 32'(sw_chg), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      latencyCheck("lat2", 19'h00009);

      // Input change landing while the FSM sits in COMMIT.
      doReset();
      c0 = chgCount;
      applyStimulus(19'h00003, 5);
      applyStimulus(19'h00006, 20);
      checkOutput("commit-chg pulses", 32'(chgCount - c0), 32'd2);
      checkOutput("commit-chg switch_o", 32'(switch_o), 32'h00006);
      checkOutput("commit-chg mask", 32'(sw_chg_mask), 32'h00005);

      // Randomized activity with occasional asynchronous resets.
      doReset();
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         r = $urandom_range(0, 99);
         if (r < 3) sw_raw = WIDTH'($urandom);
         else if (r < 10) sw_raw = sw_raw ^ (WIDTH'(1) << $urandom_range(0, WIDTH - 1));
         if ($urandom_range(0, 399) == 0) begin
            #2 rst_n = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/switch_debounce.md
SWITCH_DEBOUNCE -- requirements
Module: switch_debounce

Interface
REQ-001 SHALL have parameter: WIDTH, 19, number of switch bits conditioned.
REQ-002 SHALL have parameter: CNT_MAX, 1000000, stable-cycle count required before commit (legal range 2 to 2^24-1).
REQ-003 SHALL have port: switclk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port: switrst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port: sw_raw  input  WIDTH  unsynchronized board switch levels.
REQ-006 SHALL have port: switch_o  output  WIDTH  debounced switch vector, registered; drives the switch reader's switch_i.
REQ-007 SHALL have port: sw_chg  output  1  one-cycle pulse on each commit of a new switch_o value.
REQ-008 SHALL have port: sw_chg_mask  output  WIDTH  registered XOR of old and new switch_o at the last commit.
REQ-009 SHALL have port: sw_busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-010 SHALL pass sw_raw through a two-stage synchronizer (sync1, then sync2); only sync2 is used downstream.
REQ-011 SHALL implement an FSM with exactly three states: IDLE, COUNT, COMMIT.
REQ-012 SHALL hold a candidate register cand (WIDTH bits) and a counter cnt sized to hold CNT_MAX-1.
REQ-013 IDLE: if sync2 != switch_o, SHALL load cand <= sync2 and cnt <= 0, and go to COUNT; otherwise stay in IDLE.
REQ-014 COUNT, priority 1: if sync2 == switch_o (bounce back to the stable value), SHALL clear cnt and go to IDLE without a commit.
REQ-015 COUNT, priority 2: if sync2 != cand, SHALL load cand <= sync2, clear cnt, and stay in COUNT.
REQ-016 COUNT, priority 3: if cnt == CNT_MAX-1, SHALL go to COMMIT; otherwise SHALL increment cnt.
REQ-017 COMMIT: on the next edge, SHALL set switch_o <= cand, sw_chg_mask <= cand ^ switch_o, and sw_chg <= 1, and go to IDLE.
REQ-018 sw_chg SHALL return to 0 on the edge after it rises; it SHALL never be high for two consecutive cycles.
REQ-019 SHALL ignore sync2 while in COMMIT; any change arriving then is detected in IDLE on the following cycle.
REQ-020 sw_chg_mask SHALL hold its value between commits.
REQ-021 Latency: a sw_raw change first sampled on edge 1 and held stable SHALL update switch_o on edge CNT_MAX+4.
REQ-022 Changes on several bits within one COUNT window SHALL commit together as one vector with a single sw_chg pulse.
REQ-023 cnt SHALL never exceed CNT_MAX-1 and SHALL never wrap.

Reset
REQ-024 While switrst_n is low, SHALL force sync1, sync2, cand, cnt, switch_o, sw_chg_mask to 0, sw_chg to 0, and the FSM to IDLE, independent of switclk.
REQ-025 Reset asserted mid-COUNT or in COMMIT SHALL abort the pending commit; no sw_chg pulse SHALL follow the release of reset.
REQ-026 After reset release with sw_raw nonzero, SHALL debounce toward sw_raw as a normal change from 0.

Verification (CNT_MAX=4 for all scenarios)
REQ-027 Scenario: reset, then sw_raw 0 -> 19'h00001 held -> switch_o=19'h00001, sw_chg pulse and sw_chg_mask=19'h00001 on edge 8; sw_busy high on edges 3-7.
REQ-028 Scenario: sw_raw pulses to 19'h00010 for 2 cycles and then returns to 0 -> no commit, switch_o stays 0, sw_chg never high, FSM returns to IDLE.
REQ-029 Scenario: sw_raw toggles bit 15 every 3 cycles for 20 cycles, then holds 19'h08000 -> exactly one sw_chg, final switch_o=19'h08000.
REQ-030 Scenario: stable state 19'h7FFFF, then sw_raw 19'h00000 -> single commit with sw_chg_mask=19'h7FFFF.
REQ-031 Scenario: switrst_n pulsed low during COUNT, mid-window -> outputs 0 immediately; no pulse after release; re-debounce completes CNT_MAX+4 edges after release.
REQ-032 Scenario: sw_raw changes in the cycle the FSM is in COMMIT -> the first commit completes, and a second commit follows with its own sw_chg pulse.
